// File: rtl/t01_arb_pkg.sv
// Shared FSM state type and channel indices for the t01 request arbiter.
package t01_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam int CH_INSTR = 0;
    localparam int CH_DATA  = 1;
    localparam int CH_FSM   = 2;

endpackage

// File: rtl/t01_arb_grant.sv
// One-hot winner selection over the request vector. Fixed priority (channel 0 first) by
// default; with T01_ARB_ROUND_ROBIN_EN a rotating pointer sets where the search starts.
module t01_arb_grant #(
    parameter int NUM_CH = 3
) (
`ifdef T01_ARB_ROUND_ROBIN_EN
    input  logic              clk,
    input  logic              nRST,
    input  logic              advance,
    input  logic [NUM_CH-1:0] owner,
`endif
    input  logic [NUM_CH-1:0] req,
    output logic [NUM_CH-1:0] winner
);

    localparam logic [NUM_CH-1:0] ONE = NUM_CH'(1);

`ifdef T01_ARB_ROUND_ROBIN_EN
    localparam int PTR_W = $clog2(NUM_CH);

    logic [PTR_W-1:0]    ptr_q, ptr_d;
    logic [NUM_CH-1:0]   req_rot, win_rot;
    logic [2*NUM_CH-1:0] win_dbl;

    // Rotate so the pointer channel sits at bit 0, isolate the lowest set bit, rotate back.
    always_comb begin
        req_rot = NUM_CH'({req, req} >> ptr_q);
        win_rot = req_rot & (~req_rot + ONE);
        win_dbl = {{NUM_CH{1'b0}}, win_rot} << ptr_q;
        winner  = win_dbl[NUM_CH-1:0] | win_dbl[2*NUM_CH-1:NUM_CH];
    end

    always_comb begin
        ptr_d = ptr_q;
        for (int c = 0; c < NUM_CH; c++) begin
            if (owner[c]) begin
                ptr_d = (c == NUM_CH - 1) ? '0 : PTR_W'(c + 1);
            end
        end
    end

    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            ptr_q <= '0;
        end else if (advance) begin
            ptr_q <= ptr_d;
        end
    end
`else
    always_comb begin
        winner = req & (~req + ONE);
    end
`endif

endmodule

// File: rtl/t01_request_arbiter.sv
// Arbitrates NUM_CH requesters onto one Wishbone manager port, one transaction in flight.
// Define T01_ARB_ROUND_ROBIN_EN for round-robin arbitration; fixed priority otherwise.
module t01_request_arbiter
    import t01_arb_pkg::*;
#(
    parameter int NUM_CH = 3,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                       clk,
    input  logic                       nRST,
    input  logic [NUM_CH-1:0]          req_read,
    input  logic [NUM_CH-1:0]          req_write,
    input  logic [NUM_CH*ADDR_W-1:0]   req_adr,
    input  logic [NUM_CH*DATA_W-1:0]   req_wdata,
    input  logic [NUM_CH*DATA_W/8-1:0] req_sel,
    output logic [NUM_CH-1:0]          req_done,
    output logic [DATA_W-1:0]          req_rdata,
    output logic [NUM_CH-1:0]          grant_o,
    input  logic                       busy_o,
    input  logic [DATA_W-1:0]          cpu_dat_o,
    output logic [DATA_W-1:0]          cpu_dat_i,
    output logic [ADDR_W-1:0]          adr_i,
    output logic [DATA_W/8-1:0]        sel_i,
    output logic                       write_i,
    output logic                       read_i
);

    localparam int SEL_W = DATA_W / 8;

    state_t            state_q, state_d;
    logic [NUM_CH-1:0] req_any, winner, grant_q;
    logic [ADDR_W-1:0] adr_q, pick_adr;
    logic [DATA_W-1:0] wdata_q, pick_wdata, rdata_q;
    logic [SEL_W-1:0]  sel_q, pick_sel;
    logic              write_q, pick_write;

    assign req_any = req_read | req_write;

    t01_arb_grant #(
        .NUM_CH (NUM_CH)
    ) u_grant (
`ifdef T01_ARB_ROUND_ROBIN_EN
        .clk     (clk),
        .nRST    (nRST),
        .advance (state_q == DONE),
        .owner   (grant_q),
`endif
        .req     (req_any),
        .winner  (winner)
    );

    // Winner's request fields; a simultaneous read and write resolves to the write.
    always_comb begin
        pick_adr   = '0;
        pick_wdata = '0;
        pick_sel   = '0;
        pick_write = 1'b0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (winner[c]) begin
                pick_adr   = req_adr[c*ADDR_W +: ADDR_W];
                pick_wdata = req_wdata[c*DATA_W +: DATA_W];
                pick_sel   = req_sel[c*SEL_W +: SEL_W];
                pick_write = req_write[c];
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        read_i   = 1'b0;
        write_i  = 1'b0;
        req_done = '0;
        unique case (state_q)
            IDLE: begin
                if (|req_any) state_d = ISSUE;
            end
            ISSUE: begin
                read_i  = !write_q;
                write_i = write_q;
                state_d = WAIT;
            end
            WAIT: begin
                if (!busy_o) state_d = DONE;
            end
            DONE: begin
                req_done = grant_q;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Request fields are frozen at grant so requesters may drop or change them mid-flight.
    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            state_q <= IDLE;
            grant_q <= '0;
            adr_q   <= '0;
            wdata_q <= '0;
            sel_q   <= '0;
            write_q <= 1'b0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == IDLE && |req_any) begin
                grant_q <= winner;
                adr_q   <= pick_adr;
                wdata_q <= pick_wdata;
                sel_q   <= pick_sel;
                write_q <= pick_write;
            end
            if (state_q == DONE) begin
                grant_q <= '0;
            end
            if (state_q == WAIT && !busy_o && !write_q) begin
                rdata_q <= cpu_dat_o;
            end
        end
    end

    assign grant_o   = grant_q;
    assign adr_i     = adr_q;
    assign sel_i     = sel_q;
    assign cpu_dat_i = wdata_q;
    assign req_rdata = rdata_q;

endmodule

// File: tb/tb_t01_request_arbiter.sv
// Directed self-checking bench for t01_request_arbiter (NUM_CH=3, 32-bit address/data).
module tb_t01_request_arbiter;
    import t01_arb_pkg::*;

    localparam int NUM_CH = 3;
    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int SEL_W  = DATA_W / 8;

    logic                      clk;
    logic                      nRST;
    logic [NUM_CH-1:0]         req_read, req_write, req_done, grant_o;
    logic [NUM_CH*ADDR_W-1:0]  req_adr;
    logic [NUM_CH*DATA_W-1:0]  req_wdata;
    logic [NUM_CH*SEL_W-1:0]   req_sel;
    logic [DATA_W-1:0]         req_rdata, cpu_dat_o, cpu_dat_i;
    logic [ADDR_W-1:0]         adr_i;
    logic [SEL_W-1:0]          sel_i;
    logic                      busy_o, write_i, read_i;

    int total;
    int bad;

    t01_request_arbiter #(
        .NUM_CH (NUM_CH),
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) dut (
        .clk       (clk),
        .nRST      (nRST),
        .req_read  (req_read),
        .req_write (req_write),
        .req_adr   (req_adr),
        .req_wdata (req_wdata),
        .req_sel   (req_sel),
        .req_done  (req_done),
        .req_rdata (req_rdata),
        .grant_o   (grant_o),
        .busy_o    (busy_o),
        .cpu_dat_o (cpu_dat_o),
        .cpu_dat_i (cpu_dat_i),
        .adr_i     (adr_i),
        .sel_i     (sel_i),
        .write_i   (write_i),
        .read_i    (read_i)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        nRST = 1'b0;
        tick();
        nRST = 1'b1;
    endtask

    task automatic test_reset();
        nRST      = 1'b0;
        req_read  = 3'b111;
        req_write = '0;
        req_adr   = '0;
        req_wdata = '0;
        req_sel   = '0;
        busy_o    = 1'b1;
        cpu_dat_o = 32'hDEADBEEF;
        repeat (3) tick();
        total++; if (grant_o !== 3'b000) begin bad++; $display("FAIL rst_grant got=%b want=000", grant_o); end
        total++; if (read_i !== 1'b0 || write_i !== 1'b0) begin bad++; $display("FAIL rst_strobes got=%b%b want=00", read_i, write_i); end
        total++; if (req_done !== 3'b000) begin bad++; $display("FAIL rst_done got=%b want=000", req_done); end
        total++; if (req_rdata !== 32'h0) begin bad++; $display("FAIL rst_rdata got=%h want=0", req_rdata); end
        total++; if (adr_i !== 32'h0 || sel_i !== 4'h0 || cpu_dat_i !== 32'h0) begin bad++; $display("FAIL rst_bus got=%h/%h/%h want=0", adr_i, sel_i, cpu_dat_i); end
        req_read = '0;
        nRST     = 1'b1;
        tick();
        total++; if (grant_o !== 3'b000) begin bad++; $display("FAIL idle_grant got=%b want=000", grant_o); end
    endtask

    task automatic test_single_read();
        req_adr[CH_DATA*ADDR_W +: ADDR_W] = 32'h33000400;
        req_read  = 3'b010;
        busy_o    = 1'b1;
        cpu_dat_o = 32'hDEADBEEF;
        tick();
        total++; if (read_i !== 1'b1 || write_i !== 1'b0) begin bad++; $display("FAIL rd_issue_strobes got=%b%b want=10", read_i, write_i); end
        total++; if (grant_o !== 3'b010) begin bad++; $display("FAIL rd_grant got=%b want=010", grant_o); end
        total++; if (adr_i !== 32'h33000400) begin bad++; $display("FAIL rd_adr got=%h want=33000400", adr_i); end
        tick();
        total++; if (read_i !== 1'b0) begin bad++; $display("FAIL rd_wait_strobe got=%b want=0", read_i); end
        total++; if (adr_i !== 32'h33000400) begin bad++; $display("FAIL rd_adr_hold got=%h want=33000400", adr_i); end
        tick();
        total++; if (req_done !== 3'b000) begin bad++; $display("FAIL rd_early_done got=%b want=000", req_done); end
        busy_o = 1'b0;
        tick();
        total++; if (req_done !== 3'b010) begin bad++; $display("FAIL rd_done got=%b want=010", req_done); end
        total++; if (req_rdata !== 32'hDEADBEEF) begin bad++; $display("FAIL rd_rdata got=%h want=deadbeef", req_rdata); end
        req_read = '0;
        tick();
        total++; if (grant_o !== 3'b000 || req_done !== 3'b000) begin bad++; $display("FAIL rd_release got=%b/%b want=000/000", grant_o, req_done); end
    endtask

    // Each requester drops its request when its done pulse arrives.
    task automatic test_contention();
        logic [NUM_CH-1:0] exp_seq [4];
        int n;
        exp_seq[0] = 3'b001;
        exp_seq[1] = 3'b010;
        exp_seq[2] = 3'b100;
        exp_seq[3] = 3'b001;
        do_reset();
        busy_o   = 1'b0;
        req_read = 3'b111;
        for (int k = 0; k < 4; k++) begin
            if (k == 3) req_read = 3'b001;
            n = 0;
            do begin tick(); n++; end while (req_done == '0 && n < 20);
            total++; if (req_done !== exp_seq[k]) begin bad++; $display("FAIL cont_order%0d got=%b want=%b", k, req_done, exp_seq[k]); end
            req_read = req_read & ~req_done;
        end
        req_read = '0;
        tick();
    endtask

    // All three requests held continuously through several grants.
    task automatic test_hold();
        logic [NUM_CH-1:0] exp_seq [6];
        int n;
`ifdef T01_ARB_ROUND_ROBIN_EN
        exp_seq[0] = 3'b001; exp_seq[1] = 3'b010; exp_seq[2] = 3'b100;
        exp_seq[3] = 3'b001; exp_seq[4] = 3'b010; exp_seq[5] = 3'b100;
`else
        exp_seq[0] = 3'b001; exp_seq[1] = 3'b001; exp_seq[2] = 3'b001;
        exp_seq[3] = 3'b001; exp_seq[4] = 3'b001; exp_seq[5] = 3'b001;
`endif
        do_reset();
        busy_o   = 1'b0;
        req_read = 3'b111;
        for (int k = 0; k < 6; k++) begin
            n = 0;
            do begin tick(); n++; end while (req_done == '0 && n < 20);
            total++; if (req_done !== exp_seq[k]) begin bad++; $display("FAIL hold_order%0d got=%b want=%b", k, req_done, exp_seq[k]); end
        end
        req_read = '0;
        tick();
    endtask

    task automatic test_write();
        req_adr[CH_FSM*ADDR_W +: ADDR_W]   = 32'h33000200;
        req_wdata[CH_FSM*DATA_W +: DATA_W] = 32'h00000041;
        req_sel[CH_FSM*SEL_W +: SEL_W]     = 4'b0001;
        req_write = 3'b100;
        busy_o    = 1'b1;
        cpu_dat_o = 32'h12345678;
        tick();
        total++; if (write_i !== 1'b1 || read_i !== 1'b0) begin bad++; $display("FAIL wr_issue_strobes got=%b%b want=01", read_i, write_i); end
        total++; if ({adr_i, cpu_dat_i, sel_i} !== {32'h33000200, 32'h00000041, 4'b0001}) begin bad++; $display("FAIL wr_bus got=%h/%h/%b want=33000200/00000041/0001", adr_i, cpu_dat_i, sel_i); end
        tick();
        total++; if (write_i !== 1'b0) begin bad++; $display("FAIL wr_wait_strobe got=%b want=0", write_i); end
        busy_o = 1'b0;
        tick();
        total++; if (req_done !== 3'b100) begin bad++; $display("FAIL wr_done got=%b want=100", req_done); end
        total++; if ({adr_i, cpu_dat_i, sel_i} !== {32'h33000200, 32'h00000041, 4'b0001}) begin bad++; $display("FAIL wr_bus_hold got=%h/%h/%b want=33000200/00000041/0001", adr_i, cpu_dat_i, sel_i); end
        total++; if (req_rdata !== 32'hDEADBEEF) begin bad++; $display("FAIL wr_rdata_kept got=%h want=deadbeef", req_rdata); end
        req_write = '0;
        tick();
    endtask

    task automatic test_midflight();
        bit seen;
        req_adr[CH_INSTR*ADDR_W +: ADDR_W] = 32'h33000100;
        req_read  = 3'b001;
        busy_o    = 1'b1;
        cpu_dat_o = 32'hCAFEF00D;
        tick();
        tick();
        req_read = '0;
        req_adr[CH_INSTR*ADDR_W +: ADDR_W] = 32'h11111111;
        tick();
        total++; if (adr_i !== 32'h33000100) begin bad++; $display("FAIL mid_adr_latched got=%h want=33000100", adr_i); end
        busy_o = 1'b0;
        tick();
        total++; if (req_done !== 3'b001) begin bad++; $display("FAIL mid_drop_done got=%b want=001", req_done); end
        total++; if (req_rdata !== 32'hCAFEF00D) begin bad++; $display("FAIL mid_rdata got=%h want=cafef00d", req_rdata); end
        tick();
        req_read = 3'b010;
        busy_o   = 1'b1;
        tick();
        tick();
        total++; if (grant_o !== 3'b010) begin bad++; $display("FAIL mid_wait_grant got=%b want=010", grant_o); end
        nRST = 1'b0;
        #1;
        total++; if (grant_o !== 3'b000 || req_done !== 3'b000 || read_i !== 1'b0 || write_i !== 1'b0) begin bad++; $display("FAIL mid_rst_abort got=%b/%b/%b%b want=000/000/00", grant_o, req_done, read_i, write_i); end
        req_read = '0;
        busy_o   = 1'b0;
        tick();
        nRST = 1'b1;
        seen = 1'b0;
        for (int k = 0; k < 6; k++) begin
            tick();
            if (req_done != '0) seen = 1'b1;
        end
        total++; if (seen !== 1'b0) begin bad++; $display("FAIL mid_rst_no_done got=%b want=0", seen); end
        total++; if (req_rdata !== 32'h0) begin bad++; $display("FAIL mid_rst_rdata got=%h want=0", req_rdata); end
    endtask

    task automatic test_read_write_busy();
        bit seen;
        req_wdata[CH_DATA*DATA_W +: DATA_W] = 32'h00000055;
        req_read  = 3'b010;
        req_write = 3'b010;
        busy_o    = 1'b1;
        cpu_dat_o = 32'hA5A5A5A5;
        tick();
        total++; if (write_i !== 1'b1 || read_i !== 1'b0) begin bad++; $display("FAIL rw_strobes got=%b%b want=01", read_i, write_i); end
        seen = 1'b0;
        for (int k = 0; k < 50; k++) begin
            tick();
            if (req_done != '0) seen = 1'b1;
        end
        total++; if (seen !== 1'b0) begin bad++; $display("FAIL busy_no_done got=%b want=0", seen); end
        busy_o = 1'b0;
        tick();
        total++; if (req_done !== 3'b010) begin bad++; $display("FAIL busy_release_done got=%b want=010", req_done); end
        total++; if (req_rdata !== 32'h0) begin bad++; $display("FAIL rw_rdata_kept got=%h want=0", req_rdata); end
        req_read  = '0;
        req_write = '0;
        tick();
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_single_read();
        test_contention();
        test_hold();
        test_write();
        test_midflight();
        test_read_write_busy();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
